// File: rtl/llsc_ctrl_if.sv
// rtl/llsc_ctrl_if.sv - CPU, dcache, snoop and link-module signal bundle for llsc_ctrl
interface llsc_ctrl_if #(
  parameter int WORD_W = 32
);
  logic              cpu_ren;
  logic              cpu_wen;
  logic              cpu_atomic;
  logic [WORD_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_store;
  logic              cpu_ready;
  logic [WORD_W-1:0] cpu_rdata;

  logic              cache_ren;
  logic              cache_wen;
  logic [WORD_W-1:0] cache_addr;
  logic [WORD_W-1:0] cache_wdata;
  logic              cache_ready;
  logic [WORD_W-1:0] cache_rdata;

  logic              snoop_valid;
  logic [WORD_W-1:0] snoop_addr;

  logic [WORD_W-1:0] lm_addr_cpu;
  logic [WORD_W-1:0] lm_addr_bus;
  logic              lm_update;
  logic              lm_invalid;
  logic              lm_write_valid;

  // slave: the sequencer itself; master: the surrounding core, cache and link module
  modport slave (
    input  cpu_ren, cpu_wen, cpu_atomic, cpu_addr, cpu_store,
    output cpu_ready, cpu_rdata,
    output cache_ren, cache_wen, cache_addr, cache_wdata,
    input  cache_ready, cache_rdata,
    input  snoop_valid, snoop_addr,
    output lm_addr_cpu, lm_addr_bus, lm_update, lm_invalid,
    input  lm_write_valid
  );

  modport master (
    output cpu_ren, cpu_wen, cpu_atomic, cpu_addr, cpu_store,
    input  cpu_ready, cpu_rdata,
    input  cache_ren, cache_wen, cache_addr, cache_wdata,
    output cache_ready, cache_rdata,
    output snoop_valid, snoop_addr,
    input  lm_addr_cpu, lm_addr_bus, lm_update, lm_invalid,
    output lm_write_valid
  );
endinterface

// File: rtl/llsc_ctrl.sv
// rtl/llsc_ctrl.sv - per-core LL/SC sequencer between CPU memory port and L1 dcache
module llsc_ctrl #(
  parameter int WORD_W = 32
) (
  input logic        CLK,
  input logic        RST,
  llsc_ctrl_if.slave bus
);
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LL_ACC,
    SC_CHK,
    SC_ACC,
    DONE
  } state_t;

  state_t state, state_n;
  word_t  data_q, data_n;
  word_t  word_addr;
  logic   snoop_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      data_q <= '0;
    end else begin
      state  <= state_n;
      data_q <= data_n;
    end
  end

  always_comb begin
    state_n          = state;
    data_n           = data_q;
    word_addr        = {bus.cpu_addr[WORD_W-1:2], 2'b00};
    snoop_hit        = bus.snoop_valid && (bus.snoop_addr[WORD_W-1:2] == bus.cpu_addr[WORD_W-1:2]);
    bus.cpu_ready    = 1'b0;
    bus.cpu_rdata    = '0;
    bus.cache_ren    = 1'b0;
    bus.cache_wen    = 1'b0;
    bus.cache_addr   = '0;
    bus.cache_wdata  = '0;
    bus.lm_addr_cpu  = '0;
    bus.lm_addr_bus  = '0;
    bus.lm_update    = 1'b0;
    bus.lm_invalid   = 1'b0;

    if (RST) begin
      // Holding the link cleared while in reset keeps a stale link from surviving it
      bus.lm_invalid = 1'b1;
    end else begin
      bus.lm_addr_cpu = word_addr;
      bus.lm_addr_bus = bus.snoop_valid ? bus.snoop_addr : '0;

      case (state)
        IDLE: begin
          bus.cpu_rdata = bus.cache_rdata;
          if (bus.cpu_wen) begin
            if (bus.cpu_atomic) begin
              state_n = SC_CHK;
            end else begin
              bus.cache_wen   = 1'b1;
              bus.cache_addr  = bus.cpu_addr;
              bus.cache_wdata = bus.cpu_store;
              bus.cpu_ready   = bus.cache_ready;
              // An ordinary store from this core to the linked word breaks the link
              bus.lm_invalid  = bus.cache_ready && bus.lm_write_valid;
            end
          end else if (bus.cpu_ren) begin
            if (bus.cpu_atomic) begin
              state_n = LL_ACC;
            end else begin
              bus.cache_ren  = 1'b1;
              bus.cache_addr = bus.cpu_addr;
              bus.cpu_ready  = bus.cache_ready;
            end
          end
        end

        LL_ACC: begin
          bus.cache_ren  = 1'b1;
          bus.cache_addr = bus.cpu_addr;
          if (bus.cache_ready) begin
            bus.lm_update = 1'b1;
            data_n        = bus.cache_rdata;
            state_n       = DONE;
          end
        end

        SC_CHK: begin
          if (bus.lm_write_valid && !snoop_hit) begin
            state_n = SC_ACC;
          end else begin
            data_n  = '0;
            state_n = DONE;
          end
        end

        SC_ACC: begin
          bus.cache_wen   = 1'b1;
          bus.cache_addr  = bus.cpu_addr;
          bus.cache_wdata = bus.cpu_store;
          if (bus.cache_ready) begin
            bus.lm_invalid = 1'b1;
            data_n         = word_t'(1);
            state_n        = DONE;
          end
        end

        DONE: begin
          bus.cpu_ready = 1'b1;
          bus.cpu_rdata = data_q;
          state_n       = IDLE;
        end

        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_llsc_ctrl.sv
// tb/tb_llsc_ctrl.sv - testbench for llsc_ctrl with behavioural cache, link module and LL/SC model
module tb_llsc_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  llsc_ctrl_if #(.WORD_W(32)) bus();
  llsc_ctrl #(.WORD_W(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Environment: dcache with programmable latency and a link register
  logic [31:0] cmem [0:255];
  logic [31:0] ref_mem [0:255];
  int          lat_cfg = 0;
  int          ccnt = 0;
  logic        init_we = 1'b0;
  logic [7:0]  init_idx = '0;
  logic [31:0] init_val = '0;
  logic        link_v = 1'b0;
  logic [29:0] link_a = '0;

  assign bus.cache_ready    = (bus.cache_ren || bus.cache_wen) && (ccnt == lat_cfg);
  assign bus.cache_rdata    = cmem[bus.cache_addr[9:2]];
  assign bus.lm_write_valid = link_v && (link_a == bus.lm_addr_cpu[31:2]);

  always @(posedge CLK) begin
    if (init_we) cmem[init_idx] <= init_val;
    else if (bus.cache_wen && bus.cache_ready) cmem[bus.cache_addr[9:2]] <= bus.cache_wdata;
    if ((bus.cache_ren || bus.cache_wen) && !bus.cache_ready) ccnt <= ccnt + 1;
    else ccnt <= 0;
    if (bus.lm_update) begin
      link_v <= 1'b1;
      link_a <= bus.lm_addr_cpu[31:2];
    end else if (bus.lm_invalid) begin
      link_v <= 1'b0;
    end else if (bus.snoop_valid && link_v && bus.lm_addr_bus[31:2] == link_a) begin
      link_v <= 1'b0;
    end
  end

  task automatic idle_inputs();
    bus.cpu_ren = 0; bus.cpu_wen = 0; bus.cpu_atomic = 0;
    bus.cpu_addr = '0; bus.cpu_store = '0;
    bus.snoop_valid = 0; bus.snoop_addr = '0;
  endtask

  task automatic poke_mem(input logic [7:0] idx, input logic [31:0] val);
    init_we = 1; init_idx = idx; init_val = val;
    @(posedge CLK); #1;
    init_we = 0;
  endtask

  // kind: 0 load, 1 store, 2 LL, 3 SC. Entered and left at posedge+1.
  task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] data,
                        input int lat, input int snoop_at, input logic [31:0] snoop_a,
                        output logic [31:0] rdata, output int cycles, output int n_upd,
                        output int n_inv, output int n_wen, output logic [31:0] upd_addr,
                        output logic [31:0] wdata_seen, output logic [31:0] bus_seen);
    bit done = 0;
    rdata = '0; cycles = -1; n_upd = 0; n_inv = 0; n_wen = 0;
    upd_addr = '0; wdata_seen = '0; bus_seen = '0;
    lat_cfg = lat;
    bus.cpu_ren = (kind == 0 || kind == 2);
    bus.cpu_wen = (kind == 1 || kind == 3);
    bus.cpu_atomic = (kind >= 2);
    bus.cpu_addr = addr;
    bus.cpu_store = data;
    for (int k = 1; k <= 60 && !done; k++) begin
      if (k > 1) begin @(posedge CLK); #1; end
      bus.snoop_valid = (k == snoop_at);
      bus.snoop_addr = (k == snoop_at) ? snoop_a : 32'h0;
      @(negedge CLK);
      if (bus.lm_update) begin n_upd++; upd_addr = bus.lm_addr_cpu; end
      if (bus.lm_invalid) n_inv++;
      if (bus.cache_wen) begin n_wen++; wdata_seen = bus.cache_wdata; end
      if (k == snoop_at) bus_seen = bus.lm_addr_bus;
      if (bus.cpu_ready) begin done = 1; cycles = k; rdata = bus.cpu_rdata; end
    end
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  logic [31:0] rd, ua, wd, bs;
  int cyc, nu, ni, nw;

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    @(negedge CLK);
    checks++; if (bus.lm_invalid !== 1'b1) begin errors++; $display("FAIL reset_lm_invalid got %0b expected 1", bus.lm_invalid); end
    checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready got %0b expected 0", bus.cpu_ready); end
    checks++; if ({bus.cache_ren, bus.cache_wen, bus.lm_update} !== 3'b000) begin errors++; $display("FAIL reset_cache_req got %b expected 000", {bus.cache_ren, bus.cache_wen, bus.lm_update}); end
    @(posedge CLK); #1;
    RST = 0;
  endtask

  task automatic test_ll();
    poke_mem(8'd64, 32'hDEADBEEF);
    do_txn(2, 32'h100, 0, 3, 0, 0, rd, cyc, nu, ni, nw, ua, wd, bs);
    checks++; if (nu !== 1) begin errors++; $display("FAIL ll_update_count got %0d expected 1", nu); end
    checks++; if (ua !== 32'h100) begin errors++; $display("FAIL ll_update_addr got %0h expected 100", ua); end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL ll_latency got %0d expected 6", cyc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ll_rdata got %0h expected deadbeef", rd); end
  endtask

  task automatic test_sc_success();
    do_txn(3, 32'h100, 32'h5, 1, 0, 0, rd, cyc, nu, ni, nw, ua, wd, bs);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL sc_ok_latency got %0d expected 5", cyc); end
    checks++; if (nw !== 2 || wd !== 32'h5) begin errors++; $display("FAIL sc_ok_write got %0d/%0h expected 2/5", nw, wd); end
    checks++; if (ni !== 1 || nu !== 0) begin errors++; $display("FAIL sc_ok_pulses got inv %0d upd %0d expected 1 0", ni, nu); end
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL sc_ok_result got %0h expected 1", rd); end
  endtask

  task automatic test_sc_fail();
    do_txn(3, 32'h100, 32'h9, 0, 0, 0, rd, cyc, nu, ni, nw, ua, wd, bs);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL sc_fail_latency got %0d expected 3", cyc); end
    checks++; if (nw !== 0 || ni !== 0 || nu !== 0) begin errors++; $display("FAIL sc_fail_side got wen %0d inv %0d upd %0d expected 0 0 0", nw, ni, nu); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sc_fail_result got %0h expected 0", rd); end
  endtask

  task automatic test_sc_snoop();
    do_txn(2, 32'h100, 0, 0, 0, 0, rd, cyc, nu, ni, nw, ua, wd, bs);
    do_txn(3, 32'h100, 32'h7, 0, 2, 32'h102, rd, cyc, nu, ni, nw, ua, wd, bs);
    checks++; if (bs !== 32'h102) begin errors++; $display("FAIL snoop_bus_addr got %0h expected 102", bs); end
    checks++; if (rd !== 32'h0 || cyc !== 3) begin errors++; $display("FAIL snoop_sc_result got %0h/%0d expected 0/3", rd, cyc); end
    checks++; if (nw !== 0) begin errors++; $display("FAIL snoop_sc_wen got %0d expected 0", nw); end
  endtask

  task automatic test_store_break();
    do_txn(2, 32'h100, 0, 0, 0, 0, rd, cyc, nu, ni, nw, ua, wd, bs);
    do_txn(1, 32'h200, 32'h11, 0, 0, 0, rd, cyc, nu, ni, nw, ua, wd, bs);
    checks++; if (cyc !== 1 || ni !== 0) begin errors++; $display("FAIL store_other got cyc %0d inv %0d expected 1 0", cyc, ni); end
    do_txn(1, 32'h100, 32'h22, 0, 0, 0, rd, cyc, nu, ni, nw, ua, wd, bs);
    checks++; if (cyc !== 1 || ni !== 1) begin errors++; $display("FAIL store_linked got cyc %0d inv %0d expected 1 1", cyc, ni); end
    do_txn(3, 32'h100, 32'h33, 0, 0, 0, rd, cyc, nu, ni, nw, ua, wd, bs);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_broke_link got %0h expected 0", rd); end
  endtask

  task automatic test_reset_mid_sc();
    do_txn(2, 32'h100, 0, 0, 0, 0, rd, cyc, nu, ni, nw, ua, wd, bs);
    lat_cfg = 10;
    bus.cpu_wen = 1; bus.cpu_atomic = 1; bus.cpu_addr = 32'h100; bus.cpu_store = 32'h44;
    @(negedge CLK); @(posedge CLK); #1;
    @(negedge CLK); @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (bus.cache_wen !== 1'b1) begin errors++; $display("FAIL rst_pre_acc got %0b expected 1", bus.cache_wen); end
    @(posedge CLK); #1;
    RST = 1;
    @(negedge CLK);
    checks++; if (bus.cache_wen !== 1'b0 || bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_drop got wen %0b rdy %0b expected 0 0", bus.cache_wen, bus.cpu_ready); end
    checks++; if (bus.lm_invalid !== 1'b1) begin errors++; $display("FAIL rst_invalid got %0b expected 1", bus.lm_invalid); end
    @(posedge CLK); #1;
    idle_inputs();
    @(posedge CLK); #1;
    RST = 0;
    do_txn(0, 32'h104, 0, 0, 0, 0, rd, cyc, nu, ni, nw, ua, wd, bs);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL rst_idle_after got %0d expected 1", cyc); end
    do_txn(3, 32'h100, 32'h55, 0, 0, 0, rd, cyc, nu, ni, nw, ua, wd, bs);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_link_cleared got %0h expected 0", rd); end
  endtask

  task automatic test_random();
    bit          ref_lv = 0;
    logic [29:0] ref_la = '0;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v = $urandom;
      ref_mem[i] = v;
      poke_mem(i[7:0], v);
    end
    // Start from a known-empty link
    RST = 1; @(posedge CLK); #1; RST = 0;
    for (int n = 0; n < 80; n++) begin
      int kind = $urandom_range(0, 3);
      int lat = $urandom_range(0, 3);
      logic [31:0] addr = 32'h100 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
      logic [31:0] data = $urandom;
      logic [7:0] idx = addr[9:2];
      bit hit = ref_lv && (ref_la == addr[31:2]);
      logic [31:0] e_rd = '0;
      int e_cyc = 0, e_upd = 0, e_inv = 0, e_wen = 0;
      case (kind)
        0: begin e_rd = ref_mem[idx]; e_cyc = lat + 1; end
        1: begin e_cyc = lat + 1; e_wen = lat + 1; e_inv = hit; ref_mem[idx] = data; if (hit) ref_lv = 0; end
        2: begin e_rd = ref_mem[idx]; e_cyc = lat + 3; e_upd = 1; ref_lv = 1; ref_la = addr[31:2]; end
        default: begin
          if (hit) begin
            e_rd = 32'h1; e_cyc = lat + 4; e_wen = lat + 1; e_inv = 1; ref_mem[idx] = data; ref_lv = 0;
          end else begin
            e_rd = 32'h0; e_cyc = 3;
          end
        end
      endcase
      do_txn(kind, addr, data, lat, 0, 0, rd, cyc, nu, ni, nw, ua, wd, bs);
      checks++; if (cyc !== e_cyc) begin errors++; $display("FAIL rnd%0d_k%0d_latency got %0d expected %0d", n, kind, cyc, e_cyc); end
      checks++; if (nu !== e_upd || ni !== e_inv) begin errors++; $display("FAIL rnd%0d_k%0d_pulses got upd %0d inv %0d expected %0d %0d", n, kind, nu, ni, e_upd, e_inv); end
      checks++; if (nw !== e_wen) begin errors++; $display("FAIL rnd%0d_k%0d_wen got %0d expected %0d", n, kind, nw, e_wen); end
      if (kind != 1) begin
        checks++; if (rd !== e_rd) begin errors++; $display("FAIL rnd%0d_k%0d_rdata got %0h expected %0h", n, kind, rd, e_rd); end
      end
      if (e_upd == 1) begin
        checks++; if (ua !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL rnd%0d_upd_addr got %0h expected %0h", n, ua, {addr[31:2], 2'b00}); end
      end
      if ($urandom_range(0, 2) == 0) begin
        logic [31:0] sa = 32'h100 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
        bus.snoop_valid = 1; bus.snoop_addr = sa;
        @(negedge CLK);
        checks++; if (bus.lm_addr_bus !== sa) begin errors++; $display("FAIL rnd%0d_snoop_fwd got %0h expected %0h", n, bus.lm_addr_bus, sa); end
        if (ref_lv && ref_la == sa[31:2]) ref_lv = 0;
        @(posedge CLK); #1;
        bus.snoop_valid = 0; bus.snoop_addr = '0;
      end
    end
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    @(posedge CLK); #1;
    test_reset();
    test_ll();
    test_sc_success();
    test_sc_fail();
    test_sc_snoop();
    test_store_break();
    test_reset_mid_sc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/llsc_ctrl.md
Name: llsc_ctrl

Overview:
- Per-core atomic-access sequencer between the CPU datapath memory port and the L1 dcache.
- Recognises LL and SC, runs the cache accesses for them, and drives the link module's update, invalidate and address inputs.
- Consumes the link module's write_valid to decide SC success, then returns the SC result word (1/0) to the CPU.
- Non-atomic loads and stores pass through; own-core stores to the linked word break the link.

Parameters:
- WORD_W, 32, data/address width (word_t).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- cpu_ren  in  1  CPU load request, held until cpu_ready
- cpu_wen  in  1  CPU store request, held until cpu_ready
- cpu_atomic  in  1  request is LL (with ren) / SC (with wen)
- cpu_addr  in  32  byte address
- cpu_store  in  32  store data
- cpu_ready  out  1  request complete
- cpu_rdata  out  32  load data / SC result
- cache_ren  out  1  dcache read request
- cache_wen  out  1  dcache write request
- cache_addr  out  32  dcache address
- cache_wdata  out  32  dcache write data
- cache_ready  in  1  dcache access done this cycle
- cache_rdata  in  32  dcache read data
- snoop_valid  in  1  bus invalidating/write transaction from another core this cycle
- snoop_addr  in  32  address of that transaction
- lm_addr_cpu  out  32  word address to link/compare (cpu_addr with [1:0]=0)
- lm_addr_bus  out  32  snoop address forwarded to link module
- lm_update  out  1  one-cycle pulse: set link to lm_addr_cpu
- lm_invalid  out  1  one-cycle pulse: clear link
- lm_write_valid  in  1  combinational: link valid and link word == lm_addr_cpu

Behaviour:
- Link-module contract:
  - Link module clears its link itself when lm_addr_bus matches and snoop_valid is high.
  - lm_addr_bus = snoop_addr when snoop_valid, else 0, combinationally in every state.
  - Address comparisons use bits [31:2] only.
- Reset (RST high at posedge): state←IDLE, result/rdata regs←0.
  - While RST is high: lm_invalid=1; all other outputs 0.
- FSM states: IDLE, LL_ACC, SC_CHK, SC_ACC, DONE.
- IDLE:
  - Non-atomic pass-through: cache_ren/wen/addr/wdata = cpu_*, cpu_ready = cache_ready, cpu_rdata = cache_rdata. Zero added latency.
  - Non-atomic store completing (cpu_wen & cache_ready) with lm_write_valid=1 (lm_addr_cpu=cpu_addr): lm_invalid=1 that cycle.
  - cpu_ren & cpu_atomic → LL_ACC.
  - cpu_wen & cpu_atomic → SC_CHK.
  - cpu_wen has priority if both ren and wen are set.
- LL_ACC:
  - cache_ren=1, cache_addr=cpu_addr, until cache_ready.
  - On cache_ready: lm_update=1 with lm_addr_cpu=word(cpu_addr); capture cache_rdata; → DONE.
  - If snoop_valid matches the word in the same cycle as lm_update, update wins (link set). Last-writer ordering is guaranteed by the bus.
- SC_CHK (exactly 1 cycle, no cache request):
  - lm_addr_cpu=word(cpu_addr).
  - Success iff lm_write_valid=1 AND NOT (snoop_valid AND snoop word == cpu word).
  - Success → SC_ACC.
  - Fail → result=0, → DONE. No cache write, no lm pulse.
- SC_ACC:
  - cache_wen=1, cache_addr=cpu_addr, cache_wdata=cpu_store, until cache_ready.
  - On cache_ready: lm_invalid=1, result=1, → DONE.
  - Snoops in this state do not abort the SC. The store is already committed by the coherence protocol.
- DONE (1 cycle):
  - cpu_ready=1; cpu_rdata = LL data or SC result (32'h1 / 32'h0); → IDLE.
  - A request still asserted in the following IDLE cycle is treated as new; the CPU must drop or advance it on cpu_ready.
- Latency:
  - LL = cache latency + 1 cycle (DONE).
  - SC success = 1 (CHK) + cache latency + 1.
  - SC fail = 2 cycles.
- Outside their defined states, lm_update/lm_invalid are 0. Each pulse is exactly one cycle per event.
- RST asserted in any state: abandon access next edge; cache_ren/wen drop the cycle RST is seen.

Test Plan:
- LL 0x100, cache_ready after 3 cycles, rdata 0xDEADBEEF → lm_update single pulse with lm_addr_cpu=0x100; cpu_ready one cycle later, cpu_rdata=0xDEADBEEF.
- LL 0x100 then SC 0x100 data 0x5, lm_write_valid=1 → SC_CHK 1 cycle, cache_wen with wdata=0x5, lm_invalid pulse, cpu_rdata=1.
- SC 0x100 with lm_write_valid=0 → no cache_wen ever, no lm pulses, cpu_ready 2 cycles after request, cpu_rdata=0.
- SC 0x100, lm_write_valid=1, snoop_valid with snoop_addr=0x102 in SC_CHK cycle → fail, cpu_rdata=0, lm_addr_bus=0x102 that cycle.
- Non-atomic store 0x100 with lm_write_valid=1, cache_ready → same-cycle cpu_ready and lm_invalid pulse. Store to 0x200 with lm_write_valid=0 → no lm_invalid.
- RST mid SC_ACC → next cycle cache_wen=0, cpu_ready=0, lm_invalid=1 while RST high, state IDLE after release.
